// File: rtl/prism_sp_axi_write_arbiter.sv
// Two-requester AXI write arbiter: AW/W of one whole burst at a time, B routed back via a grant FIFO.
// Define PRISM_SP_WR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module prism_sp_axi_write_arbiter #(
   parameter int ROUTE_FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int ID_WIDTH         = 4,
   localparam int STRB_WIDTH      = DATA_WIDTH / 8,
   localparam int PTR_WIDTH       = $clog2(ROUTE_FIFO_DEPTH),
   localparam int CNT_WIDTH       = PTR_WIDTH + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   // requester 0
   input  logic [ID_WIDTH-1:0]   axi_s0_awid,
   input  logic [ADDR_WIDTH-1:0] axi_s0_awaddr,
   input  logic [7:0]            axi_s0_awlen,
   input  logic [2:0]            axi_s0_awsize,
   input  logic [1:0]            axi_s0_awburst,
   input  logic                  axi_s0_awvalid,
   output logic                  axi_s0_awready,
   input  logic [DATA_WIDTH-1:0] axi_s0_wdata,
   input  logic [STRB_WIDTH-1:0] axi_s0_wstrb,
   input  logic                  axi_s0_wlast,
   input  logic                  axi_s0_wvalid,
   output logic                  axi_s0_wready,
   output logic [ID_WIDTH-1:0]   axi_s0_bid,
   output logic [1:0]            axi_s0_bresp,
   output logic                  axi_s0_bvalid,
   input  logic                  axi_s0_bready,
   // requester 1
   input  logic [ID_WIDTH-1:0]   axi_s1_awid,
   input  logic [ADDR_WIDTH-1:0] axi_s1_awaddr,
   input  logic [7:0]            axi_s1_awlen,
   input  logic [2:0]            axi_s1_awsize,
   input  logic [1:0]            axi_s1_awburst,
   input  logic                  axi_s1_awvalid,
   output logic                  axi_s1_awready,
   input  logic [DATA_WIDTH-1:0] axi_s1_wdata,
   input  logic [STRB_WIDTH-1:0] axi_s1_wstrb,
   input  logic                  axi_s1_wlast,
   input  logic                  axi_s1_wvalid,
   output logic                  axi_s1_wready,
   output logic [ID_WIDTH-1:0]   axi_s1_bid,
   output logic [1:0]            axi_s1_bresp,
   output logic                  axi_s1_bvalid,
   input  logic                  axi_s1_bready,
   // shared master port
   output logic [ID_WIDTH-1:0]   axi_m_awid,
   output logic [ADDR_WIDTH-1:0] axi_m_awaddr,
   output logic [7:0]            axi_m_awlen,
   output logic [2:0]            axi_m_awsize,
   output logic [1:0]            axi_m_awburst,
   output logic                  axi_m_awvalid,
   input  logic                  axi_m_awready,
   output logic [DATA_WIDTH-1:0] axi_m_wdata,
   output logic [STRB_WIDTH-1:0] axi_m_wstrb,
   output logic                  axi_m_wlast,
   output logic                  axi_m_wvalid,
   input  logic                  axi_m_wready,
   input  logic [ID_WIDTH-1:0]   axi_m_bid,
   input  logic [1:0]            axi_m_bresp,
   input  logic                  axi_m_bvalid,
   output logic                  axi_m_bready,
   // status
   output logic                  grant,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  outstanding
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_reg;
   logic                 grant_reg;
   logic                 busy_reg;
   logic                 aw_done_reg;
   logic                 w_done_reg;
   logic [CNT_WIDTH-1:0] count_reg;
   logic [PTR_WIDTH-1:0] wr_ptr_reg;
   logic [PTR_WIDTH-1:0] rd_ptr_reg;
   logic                 route_mem [ROUTE_FIFO_DEPTH];

   // requester channels gathered into arrays so the muxes index by grant
   logic [1:0]            s_awvalid, s_wvalid, s_wlast, s_bready;
   logic [1:0]            s_awready, s_wready, s_bvalid;
   logic [ID_WIDTH-1:0]   s_awid   [2];
   logic [ADDR_WIDTH-1:0] s_awaddr [2];
   logic [7:0]            s_awlen  [2];
   logic [2:0]            s_awsize [2];
   logic [1:0]            s_awburst[2];
   logic [DATA_WIDTH-1:0] s_wdata  [2];
   logic [STRB_WIDTH-1:0] s_wstrb  [2];
   logic [ID_WIDTH-1:0]   s_bid    [2];
   logic [1:0]            s_bresp  [2];

   assign s_awvalid = {axi_s1_awvalid, axi_s0_awvalid};
   assign s_wvalid  = {axi_s1_wvalid,  axi_s0_wvalid};
   assign s_wlast   = {axi_s1_wlast,   axi_s0_wlast};
   assign s_bready  = {axi_s1_bready,  axi_s0_bready};
   assign s_awid    = '{axi_s0_awid,    axi_s1_awid};
   assign s_awaddr  = '{axi_s0_awaddr,  axi_s1_awaddr};
   assign s_awlen   = '{axi_s0_awlen,   axi_s1_awlen};
   assign s_awsize  = '{axi_s0_awsize,  axi_s1_awsize};
   assign s_awburst = '{axi_s0_awburst, axi_s1_awburst};
   assign s_wdata   = '{axi_s0_wdata,   axi_s1_wdata};
   assign s_wstrb   = '{axi_s0_wstrb,   axi_s1_wstrb};

   logic aw_fwd, w_fwd, aw_hs, w_last_hs, b_hs, fifo_empty, head, can_grant, win;

   assign aw_fwd = (state_reg == BUSY) && !aw_done_reg;
   assign w_fwd  = (state_reg == BUSY) && !w_done_reg;

   assign axi_m_awid    = s_awid[grant_reg];
   assign axi_m_awaddr  = s_awaddr[grant_reg];
   assign axi_m_awlen   = s_awlen[grant_reg];
   assign axi_m_awsize  = s_awsize[grant_reg];
   assign axi_m_awburst = s_awburst[grant_reg];
   assign axi_m_awvalid = aw_fwd && s_awvalid[grant_reg];
   assign axi_m_wdata   = s_wdata[grant_reg];
   assign axi_m_wstrb   = s_wstrb[grant_reg];
   assign axi_m_wlast   = s_wlast[grant_reg];
   assign axi_m_wvalid  = w_fwd && s_wvalid[grant_reg];

   assign aw_hs     = axi_m_awvalid && axi_m_awready;
   assign w_last_hs = axi_m_wvalid && axi_m_wready && axi_m_wlast;

   assign fifo_empty   = (count_reg == '0);
   assign head         = route_mem[rd_ptr_reg];
   assign axi_m_bready = !fifo_empty && s_bready[head];
   assign b_hs         = axi_m_bvalid && axi_m_bready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slave
         logic b_sel;
         assign b_sel         = !fifo_empty && (head == 1'(gi));
         assign s_awready[gi] = aw_fwd && (grant_reg == 1'(gi)) && axi_m_awready;
         assign s_wready[gi]  = w_fwd && (grant_reg == 1'(gi)) && axi_m_wready;
         assign s_bvalid[gi]  = b_sel && axi_m_bvalid;
         assign s_bid[gi]     = b_sel ? axi_m_bid : '0;
         assign s_bresp[gi]   = b_sel ? axi_m_bresp : 2'b00;
      end
   endgenerate

   assign axi_s0_awready = s_awready[0];
   assign axi_s1_awready = s_awready[1];
   assign axi_s0_wready  = s_wready[0];
   assign axi_s1_wready  = s_wready[1];
   assign axi_s0_bvalid  = s_bvalid[0];
   assign axi_s1_bvalid  = s_bvalid[1];
   assign axi_s0_bid     = s_bid[0];
   assign axi_s1_bid     = s_bid[1];
   assign axi_s0_bresp   = s_bresp[0];
   assign axi_s1_bresp   = s_bresp[1];

   // Full check is done before granting, so a later AW push always has room.
   assign can_grant = (count_reg < CNT_WIDTH'(ROUTE_FIFO_DEPTH));

`ifdef PRISM_SP_WR_ARB_FIXED_PRIO_EN
   assign win = !s_awvalid[0];
`else
   assign win = (&s_awvalid) ? !grant_reg : !s_awvalid[0];
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         grant_reg   <= 1'b1;
         busy_reg    <= 1'b0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         count_reg   <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if ((|s_awvalid) && can_grant) begin
                  grant_reg   <= win;
                  aw_done_reg <= 1'b0;
                  w_done_reg  <= 1'b0;
                  state_reg   <= BUSY;
                  busy_reg    <= 1'b1;
               end
            end
            BUSY: begin
               if (aw_hs)
                  aw_done_reg <= 1'b1;
               if (w_last_hs)
                  w_done_reg <= 1'b1;
               if ((aw_done_reg || aw_hs) && (w_done_reg || w_last_hs)) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (aw_hs)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (b_hs)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (aw_hs && !b_hs)
            count_reg <= count_reg + 1'b1;
         else if (b_hs && !aw_hs)
            count_reg <= count_reg - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (aw_hs)
         route_mem[wr_ptr_reg] <= grant_reg;
   end

   assign grant       = grant_reg;
   assign busy        = busy_reg;
   assign outstanding = count_reg;

endmodule

// File: tb/tb_prism_sp_axi_write_arbiter.sv
// Directed bench for prism_sp_axi_write_arbiter: cycle-stepped requester and master models,
// expected grant orders and counts written out by hand (fixed-priority variants under the macro).
module tb_prism_sp_axi_write_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [3:0]  s_awid    [2];
   logic [31:0] s_awaddr  [2];
   logic [7:0]  s_awlen   [2];
   logic [2:0]  s_awsize  [2];
   logic [1:0]  s_awburst [2];
   logic [31:0] s_wdata   [2];
   logic [3:0]  s_wstrb   [2];
   logic [3:0]  s_bid     [2];
   logic [1:0]  s_bresp   [2];
   logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;

   logic [3:0]  m_awid;
   logic [31:0] m_awaddr;
   logic [7:0]  m_awlen;
   logic [2:0]  m_awsize;
   logic [1:0]  m_awburst;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wlast, m_wvalid, m_wready;
   logic [3:0]  m_bid;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready;
   logic        grant, busy;
   logic [2:0]  outstanding;

   prism_sp_axi_write_arbiter #(.ROUTE_FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .axi_s0_awid(s_awid[0]), .axi_s0_awaddr(s_awaddr[0]), .axi_s0_awlen(s_awlen[0]),
      .axi_s0_awsize(s_awsize[0]), .axi_s0_awburst(s_awburst[0]),
      .axi_s0_awvalid(s_awvalid[0]), .axi_s0_awready(s_awready[0]),
      .axi_s0_wdata(s_wdata[0]), .axi_s0_wstrb(s_wstrb[0]), .axi_s0_wlast(s_wlast[0]),
      .axi_s0_wvalid(s_wvalid[0]), .axi_s0_wready(s_wready[0]),
      .axi_s0_bid(s_bid[0]), .axi_s0_bresp(s_bresp[0]),
      .axi_s0_bvalid(s_bvalid[0]), .axi_s0_bready(s_bready[0]),
      .axi_s1_awid(s_awid[1]), .axi_s1_awaddr(s_awaddr[1]), .axi_s1_awlen(s_awlen[1]),
      .axi_s1_awsize(s_awsize[1]), .axi_s1_awburst(s_awburst[1]),
      .axi_s1_awvalid(s_awvalid[1]), .axi_s1_awready(s_awready[1]),
      .axi_s1_wdata(s_wdata[1]), .axi_s1_wstrb(s_wstrb[1]), .axi_s1_wlast(s_wlast[1]),
      .axi_s1_wvalid(s_wvalid[1]), .axi_s1_wready(s_wready[1]),
      .axi_s1_bid(s_bid[1]), .axi_s1_bresp(s_bresp[1]),
      .axi_s1_bvalid(s_bvalid[1]), .axi_s1_bready(s_bready[1]),
      .axi_m_awid(m_awid), .axi_m_awaddr(m_awaddr), .axi_m_awlen(m_awlen),
      .axi_m_awsize(m_awsize), .axi_m_awburst(m_awburst),
      .axi_m_awvalid(m_awvalid), .axi_m_awready(m_awready),
      .axi_m_wdata(m_wdata), .axi_m_wstrb(m_wstrb), .axi_m_wlast(m_wlast),
      .axi_m_wvalid(m_wvalid), .axi_m_wready(m_wready),
      .axi_m_bid(m_bid), .axi_m_bresp(m_bresp), .axi_m_bvalid(m_bvalid), .axi_m_bready(m_bready),
      .grant(grant), .busy(busy), .outstanding(outstanding)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   // requester models
   logic [31:0] base_addr [2] = '{32'h1000, 32'h2000};
   logic [3:0]  req_id    [2] = '{4'd1, 4'd2};
   int   bursts_left [2];
   int   burst_len   [2];
   int   burst_no    [2];
   int   beat        [2];
   bit   aw_sent     [2];
   bit   w_sent      [2];
   int   b_count     [2];
   logic [1:0] last_bresp [2];
   int   bad_bid;

   // master model
   logic [3:0]  b_pending [$];
   logic [31:0] aw_log [$];
   int          aw_cyc [$];
   int          b_budget;
   logic [1:0]  b_resp_cfg;
   int          cyc;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_all();
      for (int n = 0; n < 2; n++) begin
         s_awvalid[n] = (bursts_left[n] > 0) && !aw_sent[n];
         s_awaddr[n]  = base_addr[n] + 32'(burst_no[n]) * 32'h100;
         s_awlen[n]   = 8'(burst_len[n] - 1);
         s_awid[n]    = req_id[n];
         s_awsize[n]  = 3'd2;
         s_awburst[n] = 2'd1;
         s_wvalid[n]  = (bursts_left[n] > 0) && !w_sent[n];
         s_wdata[n]   = base_addr[n] + 32'(beat[n]);
         s_wstrb[n]   = 4'hf;
         s_wlast[n]   = (beat[n] == burst_len[n] - 1);
         s_bready[n]  = 1'b1;
      end
      m_bvalid = (b_budget > 0) && (b_pending.size() > 0);
      m_bid    = (b_pending.size() > 0) ? b_pending[0] : 4'd0;
      m_bresp  = b_resp_cfg;
   endtask

   task automatic start_req(input int n, input int bursts, input int len);
      bursts_left[n] = bursts;
      burst_len[n]   = len;
      burst_no[n]    = 0;
      beat[n]        = 0;
      aw_sent[n]     = 1'b0;
      w_sent[n]      = 1'b0;
      drive_all();
   endtask

   // Called and returning at a falling edge: sample handshakes, clock once, advance models.
   task automatic step();
      logic aw_hs [2];
      logic w_hs [2];
      logic w_last_hs [2];
      logic b_hs [2];
      logic [1:0] bresp_smp [2];
      logic [3:0] bid_smp [2];
      logic m_aw_hs, m_b_hs;
      logic [31:0] awaddr_smp;
      logic [3:0] awid_smp;
      #1;
      for (int n = 0; n < 2; n++) begin
         aw_hs[n]     = s_awvalid[n] && s_awready[n];
         w_hs[n]      = s_wvalid[n] && s_wready[n];
         w_last_hs[n] = w_hs[n] && s_wlast[n];
         b_hs[n]      = s_bvalid[n] && s_bready[n];
         bresp_smp[n] = s_bresp[n];
         bid_smp[n]   = s_bid[n];
      end
      m_aw_hs    = m_awvalid && m_awready;
      m_b_hs     = m_bvalid && m_bready;
      awaddr_smp = m_awaddr;
      awid_smp   = m_awid;
      @(posedge clock);
      #1;
      cyc++;
      if (m_aw_hs) begin
         aw_log.push_back(awaddr_smp);
         aw_cyc.push_back(cyc);
         b_pending.push_back(awid_smp);
      end
      if (m_b_hs) begin
         void'(b_pending.pop_front());
         b_budget--;
      end
      for (int n = 0; n < 2; n++) begin
         if (aw_hs[n]) aw_sent[n] = 1'b1;
         if (w_hs[n]) begin
            if (w_last_hs[n]) w_sent[n] = 1'b1;
            else beat[n]++;
         end
         if (b_hs[n]) begin
            b_count[n]++;
            last_bresp[n] = bresp_smp[n];
            if (bid_smp[n] != req_id[n]) bad_bid++;
         end
         if (bursts_left[n] > 0 && aw_sent[n] && w_sent[n]) begin
            bursts_left[n]--;
            burst_no[n]++;
            aw_sent[n] = 1'b0;
            w_sent[n]  = 1'b0;
            beat[n]    = 0;
         end
      end
      drive_all();
      @(negedge clock);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int n = 0; n < 2; n++) begin
         bursts_left[n] = 0; burst_len[n] = 1; burst_no[n] = 0; beat[n] = 0;
         aw_sent[n] = 1'b0; w_sent[n] = 1'b0; b_count[n] = 0; last_bresp[n] = 2'b00;
      end
      bad_bid = 0;
      b_pending.delete();
      aw_log.delete();
      aw_cyc.delete();
      m_awready  = 1'b1;
      m_wready   = 1'b1;
      b_budget   = 1000;
      b_resp_cfg = 2'b00;
      drive_all();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      cyc = 0;
      do_reset();
      #1;
      check_vec("rst_grant", grant, 1);
      check_vec("rst_busy", busy, 0);
      check_vec("rst_outstanding", outstanding, 0);
      check_vec("rst_m_awvalid", m_awvalid, 0);
      check_vec("rst_m_wvalid", m_wvalid, 0);
      check_vec("rst_m_bready", m_bready, 0);
      check_vec("rst_s_awready", {s_awready, s_wready, s_bvalid}, 0);

      // single 1-beat request from s0
      start_req(0, 1, 1);
      #1;
      check_vec("single_no_comb_path", m_awvalid, 0);
      step();
      check_vec("single_busy", busy, 1);
      check_vec("single_grant", grant, 0);
      check_vec("single_m_awvalid", m_awvalid, 1);
      check_vec("single_m_awaddr", m_awaddr, 32'h1000);
      check_vec("single_m_wdata", m_wdata, 32'h1000);
      check_vec("single_m_wlast", m_wlast, 1);
      check_vec("single_s1_ready", {s_awready[1], s_wready[1]}, 0);
      check_vec("single_out0", outstanding, 0);
      step();
      check_vec("single_idle", busy, 0);
      check_vec("single_out1", outstanding, 1);
      check_vec("single_s0_bvalid", s_bvalid[0], 1);
      check_vec("single_s0_bresp", s_bresp[0], 0);
      check_vec("single_s1_bvalid", s_bvalid[1], 0);
      step();
      check_vec("single_out_back0", outstanding, 0);
      check_vec("single_b_count", b_count[0], 1);

      // tie, two 2-beat bursts each
      do_reset();
      start_req(0, 2, 2);
      start_req(1, 2, 2);
      run(16);
      check_vec("tie_aw_count", aw_log.size(), 4);
      check_vec("tie_aw0", aw_log[0], 32'h1000);
`ifdef PRISM_SP_WR_ARB_FIXED_PRIO_EN
      check_vec("tie_aw1", aw_log[1], 32'h1100);
      check_vec("tie_aw2", aw_log[2], 32'h2000);
`else
      check_vec("tie_aw1", aw_log[1], 32'h2000);
      check_vec("tie_aw2", aw_log[2], 32'h1100);
`endif
      check_vec("tie_aw3", aw_log[3], 32'h2100);
      for (int i = 1; i < 4; i++)
         check_vec($sformatf("tie_spacing%0d", i), aw_cyc[i] - aw_cyc[i-1], 3);
      check_vec("tie_b0", b_count[0], 2);
      check_vec("tie_b1", b_count[1], 2);
      check_vec("tie_bad_bid", bad_bid, 0);
      check_vec("tie_out", outstanding, 0);

      // full route FIFO with B withheld
      do_reset();
      b_budget = 0;
      start_req(0, 3, 1);
      start_req(1, 3, 1);
      run(20);
      check_vec("full_aw_count", aw_log.size(), 4);
      check_vec("full_out", outstanding, 4);
      check_vec("full_busy", busy, 0);
      check_vec("full_m_awvalid", m_awvalid, 0);
      check_vec("full_awready", s_awready, 0);
      b_budget = 1;
      drive_all();
      run(10);
      check_vec("full_one_more", aw_log.size(), 5);
`ifdef PRISM_SP_WR_ARB_FIXED_PRIO_EN
      check_vec("full_fifth", aw_log[4], 32'h2100);
`else
      check_vec("full_fifth", aw_log[4], 32'h1200);
`endif
      check_vec("full_out_again", outstanding, 4);
      check_vec("full_b0", b_count[0], 1);
      check_vec("full_b1", b_count[1], 0);
      b_budget = 1000;
      drive_all();
      run(30);
      check_vec("full_drain_aw", aw_log.size(), 6);
      check_vec("full_drain_out", outstanding, 0);
      check_vec("full_drain_b", b_count[0] * 16 + b_count[1], 3 * 16 + 3);

      // AW held off while W completes, then SLVERR response
      do_reset();
      m_awready  = 1'b0;
      b_resp_cfg = 2'b10;
      start_req(1, 1, 1);
      step();
      check_vec("split_m_wvalid", m_wvalid, 1);
      step();
      check_vec("split_w_done", m_wvalid, 0);
      for (int i = 0; i < 3; i++) begin
         check_vec($sformatf("split_hold%0d", i), {busy, m_awvalid}, 2'b11);
         if (i < 2) step();
      end
      m_awready = 1'b1;
      step();
      check_vec("split_idle", busy, 0);
      check_vec("split_out", outstanding, 1);
      check_vec("split_s1_bvalid", s_bvalid, 2'b10);
      check_vec("split_s1_bresp", s_bresp[1], 2'b10);
      step();
      check_vec("split_bresp_recv", last_bresp[1], 2'b10);
      check_vec("split_out0", outstanding, 0);

      // reset during beat 2 of a 4-beat burst
      do_reset();
      b_budget = 0;
      start_req(0, 1, 4);
      run(3);
      check_vec("rst_mid_beat", {m_wvalid, m_wdata[3:0]}, {1'b1, 4'h2});
      check_vec("rst_mid_out", outstanding, 1);
      reset = 1'b1;
      #1;
      check_vec("rst_mid_m_valid", {m_awvalid, m_wvalid, m_bready}, 0);
      check_vec("rst_mid_s_ready", {s_awready, s_wready, s_bvalid}, 0);
      check_vec("rst_mid_out0", outstanding, 0);
      check_vec("rst_mid_busy", busy, 0);
      do_reset();
      start_req(1, 1, 2);
      run(8);
      check_vec("post_rst_aw", aw_log.size(), 1);
      check_vec("post_rst_addr", aw_log[0], 32'h2000);
      check_vec("post_rst_b", b_count[1], 1);
      check_vec("post_rst_out", outstanding, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/prism_sp_axi_write_arbiter.md
# prism_sp_axi_write_arbiter

Two-requester AXI write-path arbiter for the SP puzzle hardware. It shares one AXI master write port (AW/W/B) between two write-side puzzle stages, e.g. the RX and TX ring-release stages that write back descriptors through the same master. It sequences whole bursts: address, all data beats, and routing of the write response back to the issuing requester. Reads are not touched.

## Interface
Parameters:
- `ROUTE_FIFO_DEPTH`, default 4: maximum outstanding (AW accepted, B not yet returned) bursts; power of two, at least 2.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `axi_s0_aw` / `axi_s0_w` / `axi_s0_b`  slave  intf  requester 0 write channels (`axi_write_address_channel`, `axi_write_channel`, `axi_write_response_channel`).
- `axi_s1_aw` / `axi_s1_w` / `axi_s1_b`  slave  intf  requester 1 write channels.
- `axi_m_aw` / `axi_m_w` / `axi_m_b`  master  intf  shared downstream write port; widths equal to the slave widths.
- `grant`  out  1  index of the current or last granted requester.
- `busy`  out  1  high while a burst is being forwarded (state BUSY).
- `outstanding`  out  $clog2(ROUTE_FIFO_DEPTH)+1  route FIFO occupancy.

## Operation
- States: IDLE and BUSY; flags `aw_done` and `w_done`.
- Request: requester n requests when `axi_sn_aw.awvalid`=1. A W beat arriving before its AW waits and does not request.
- IDLE: arbitrate only if `outstanding` < ROUTE_FIFO_DEPTH. Arbitration is round-robin: on a tie, the requester not granted last wins. A single requester wins immediately. On a win: register `grant`, clear both flags, go to BUSY.
- BUSY forwarding (combinational passthrough for the granted requester only):
  - `axi_m_aw` carries the granted requester's AW while !aw_done.
  - `axi_m_w` carries the granted requester's W while !w_done.
  - The non-granted requester sees awready=wready=0.
- AW handshake on the master: push `grant` into the route FIFO and set aw_done.
- W handshake with wlast=1: set w_done.
- When both flags are set (including both set in the same cycle), return to IDLE on the next edge.
- B routing:
  - Master bready = the bready of the requester at the route FIFO head; forced to 0 when the FIFO is empty.
  - Bvalid, bresp and bid go only to the head requester.
  - A B handshake pops the FIFO.
  - bresp is forwarded unchanged.
- Push and pop in the same cycle leave `outstanding` unchanged. The full check happens at grant time, so a push can never overflow.
- A B arriving with the FIFO empty stalls on the master side indefinitely. This is a protocol error upstream, not handled here.
- Reset mid-burst: state goes to IDLE, the FIFO empties, and all valid/ready outputs go to 0 immediately. Outstanding responses are lost; requesters must be reset together.

## Timing
- Reset values:
  - state IDLE, `grant`=1 (so requester 0 wins the first tie), `busy`=0, `outstanding`=0.
  - All master-side awvalid, wvalid, bready = 0.
  - All slave-side awready, wready, bvalid = 0.
- Grant latency: request seen in IDLE at cycle t, forwarded to the master at t+1. No combinational path from a request to the master outputs.
- Throughput: with an always-ready master, a single-beat burst takes 2 cycles (IDLE, BUSY). An N-beat burst takes N+1 cycles.
- Ready and valid are passthrough in BUSY with zero added latency. B is passthrough with zero latency.

## Configuration
- `PRISM_SP_WR_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, requester 0 always wins a tie and the last-granted history is ignored. Used when requester 0 is latency-critical (RX release).
  - Undefined: round-robin as described above.

## Test plan
- Single request: s0 issues AW addr 0x1000, 1 beat, master always ready. Master AW appears 1 cycle after awvalid; s0 receives B with OKAY; `outstanding` goes 0→1→0.
- Tie, round-robin: s0 and s1 both hold 2-beat bursts continuously. Grants go 0,1,0,1; each burst occupies 3 cycles; B responses return to the correct requesters in order.
- Tie with `PRISM_SP_WR_ARB_FIXED_PRIO_EN` defined: same stimulus. Every grant goes to s0; s1 is granted only after s0 drops awvalid.
- Full FIFO: depth 4, master B withheld, s0 and s1 alternate. Exactly 4 AWs are accepted, then awready stays 0. Releasing one B permits exactly one further grant.
- Split handshakes and stalls:
  - Master awready is delayed 3 cycles while W completes first: BUSY holds until AW is accepted, then returns to IDLE.
  - A master bresp of SLVERR reaches the correct requester unchanged.
- Reset during beat 2 of a 4-beat burst: all valids and readies drop in the same cycle, `outstanding`=0. A new s1 request afterwards is granted normally.
